// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the 8-iteration shift-add multiplier: sequences the iteration
// counter and datapath enables, with a start/ready/done handshake and a carryout watchdog.
module mult_ctrl_fsm #(
  parameter int WDOG_MAX = 15,
  parameter int WDOG_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic carryout,
  input  logic mbit,
  input  logic err_clr,
  output logic initcnt,
  output logic encnt,
  output logic ld_a,
  output logic ld_b,
  output logic clr_acc,
  output logic add_en,
  output logic shift_en,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_INIT = 3'd2,
    S_CALC = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [WDOG_W-1:0] wdog_inc;
  logic              trip;
  logic              strobe_ok;

  // Saturating increment; trip on the CALC cycle that brings the count to WDOG_MAX.
  assign wdog_inc = (wdog_q == {WDOG_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
  assign trip     = (state_q == S_CALC) && !carryout && (wdog_inc == WDOG_W'(WDOG_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM:  if (!start) state_d = S_INIT;
      S_INIT: begin
        wdog_d  = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        wdog_d = wdog_inc;
        if (carryout)  state_d = S_DONE;
        else if (trip) state_d = S_ERR;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR:  if (err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Iteration strobes drop on the carryout cycle so the counter sees exactly 8 enables.
  assign strobe_ok = (state_q == S_CALC) && !carryout && !trip;

  always_comb begin
    initcnt  = 1'b0;
    encnt    = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    clr_acc  = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      S_IDLE: ready = 1'b1;
      S_ARM: begin
        ld_a = 1'b1;
        ld_b = 1'b1;
      end
      S_INIT: begin
        initcnt = 1'b1;
        clr_acc = 1'b1;
        busy    = 1'b1;
      end
      S_CALC: begin
        busy     = 1'b1;
        encnt    = strobe_ok;
        shift_en = strobe_ok;
        add_en   = strobe_ok & mbit;
      end
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Bench for mult_ctrl_fsm: per-cycle vector table, hand sequences for the watchdog
// and mid-operation reset, and random operations checked at transaction level.
module tb_mult_ctrl_fsm;

  logic clk = 1'b0;
  logic rst, start, carryout, mbit, err_clr;
  logic initcnt, encnt, ld_a, ld_b, clr_acc, add_en, shift_en, ready, busy, done, err;

  always #5 clk = ~clk;

  mult_ctrl_fsm #(.WDOG_MAX(15), .WDOG_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .carryout(carryout), .mbit(mbit),
    .err_clr(err_clr), .initcnt(initcnt), .encnt(encnt), .ld_a(ld_a), .ld_b(ld_b),
    .clr_acc(clr_acc), .add_en(add_en), .shift_en(shift_en), .ready(ready),
    .busy(busy), .done(done), .err(err)
  );

  // Attached iteration counter and datapath; table mode drives carryout/mbit directly.
  logic       use_model, co_drv, mbit_drv;
  logic [7:0] a_in, b_in, areg, breg, acc;
  logic [2:0] cnt_q;
  logic       co_q;
  wire  [8:0] dp_sum = {1'b0, acc} + (add_en ? {1'b0, areg} : 9'd0);

  assign carryout = use_model ? co_q : co_drv;
  assign mbit     = use_model ? breg[0] : mbit_drv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      co_q  <= 1'b0;
    end else if (initcnt) begin
      cnt_q <= '0;
      co_q  <= 1'b0;
    end else begin
      co_q <= encnt && (cnt_q == 3'd7);
      if (encnt) cnt_q <= cnt_q + 3'd1;
    end
  end

  always @(posedge clk) begin
    if (ld_a) areg <= a_in;
    if (ld_b) breg <= b_in;
    if (clr_acc) acc <= '0;
    else if (shift_en) begin
      acc  <= dp_sum[8:1];
      breg <= {dp_sum[0], breg[7:1]};
    end
  end

  wire [10:0] ov = {initcnt, encnt, ld_a, ld_b, clr_acc, add_en, shift_en, ready, busy, done, err};
  localparam logic [10:0] O_IC = 11'h400, O_EN = 11'h200, O_LA = 11'h100, O_LB = 11'h080,
                          O_CA = 11'h040, O_AD = 11'h020, O_SH = 11'h010, O_RD = 11'h008,
                          O_BZ = 11'h004, O_DN = 11'h002, O_ER = 11'h001;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       st, co, mb, ec;
    logic [10:0] exp;
  } vec_t;
  vec_t tv[15];

  // One full operation through the handshake, checked against a*b and timing rules.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    int ld = 0, enc = 0, add = 0, k = 0;
    bit got = 0, seen_init = 0, order_bad = 0;
    logic [7:0] add_pat = '0;
    use_model = 1'b1;
    a_in = a;
    b_in = b;
    @(posedge clk); #1 start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ld_a) ld++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    while (k < 40) begin
      @(negedge clk);
      if (ld_a) ld++;
      if (initcnt) seen_init = 1;
      if (encnt) begin
        if (!seen_init) order_bad = 1;
        if (enc < 8) add_pat[enc] = add_en;
        enc++;
      end
      if (add_en) add++;
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("latency", got ? k : -1, 11);
    chk("arm_cycles", ld, hold);
    chk("encnt_count", enc, 8);
    chk("add_count", add, $countones(b));
    chk("add_pattern", int'(add_pat), int'(b));
    chk("init_first", int'(order_bad), 0);
    chk("product", int'({acc, breg}), int'(a) * int'(b));
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after", int'(ready), 1);
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int calc, enc, k;
    rst = 1'b1; start = 1'b0; err_clr = 1'b0; use_model = 1'b0;
    co_drv = 1'b0; mbit_drv = 1'b0; a_in = '0; b_in = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", int'(ov), int'(O_RD));
    @(posedge clk); #1 rst = 1'b0;

    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_RD};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_RD};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_LA | O_LB};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_LA | O_LB};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_IC | O_CA | O_BZ};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, O_EN | O_SH | O_AD | O_BZ};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, O_EN | O_SH | O_BZ};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, O_BZ};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, O_DN};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, O_RD};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, O_LA | O_LB};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, O_IC | O_CA | O_BZ};
    tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, O_BZ};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, O_DN};
    tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, O_RD};

    for (int i = 0; i < 15; i++) begin
      start = tv[i].st; co_drv = tv[i].co; mbit_drv = tv[i].mb; err_clr = tv[i].ec;
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'(ov), int'(tv[i].exp));
      @(posedge clk); #1;
    end
    co_drv = 1'b0;

    do_op(8'h05, 8'h8D, 3);

    // Watchdog: carryout never arrives.
    use_model = 1'b0; co_drv = 1'b0; mbit_drv = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    calc = 0; enc = 0; k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (err) break;
      if (busy && !initcnt) calc++;
      if (encnt) enc++;
      @(posedge clk); #1;
      k++;
    end
    chk("wdog_calc_cycles", calc, 15);
    chk("wdog_strobes", enc, 14);
    chk("wdog_err", int'(ov), int'(O_ER));
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_sticky", int'(ov), int'(O_ER));
    end
    @(posedge clk); #1 start = 1'b0; err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", int'(ov), int'(O_RD));

    // Asynchronous reset during the 4th CALC cycle.
    use_model = 1'b1; a_in = 8'h3C; b_in = 8'hA7;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    enc = 0; k = 0;
    while (k < 40 && enc < 4) begin
      @(negedge clk);
      if (encnt) enc++;
      if (enc < 4) begin
        @(posedge clk); #1;
      end
      k++;
    end
    chk("rst_reached_calc4", enc, 4);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outputs", int'(ov), int'(O_RD));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", int'(ov), int'(O_RD));
    do_op(8'h3C, 8'hA7, 2);

    // Random back-to-back operations.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n == 0) ra = 8'hFF;
      if (n == 0) rb = 8'hFF;
      if (n == 1) rb = 8'h00;
      do_op(ra, rb, int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
